// File: rtl/palette_bank_ram_if.sv
// Host/video/fill signal bundle for palette_bank_ram.
// The pixel pipeline, register block and fill controller drive the master side.
interface palette_bank_ram_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned BANKS  = 2
);
  localparam int unsigned BANK_W = $clog2(BANKS);
  localparam int unsigned FLAT_W = BANK_W + ADDR_W;

  // video read port
  logic              vid_rd_en_i;
  logic [BANK_W-1:0] vid_bank_i;
  logic [ADDR_W-1:0] vid_addr_i;
  logic [DATA_W-1:0] vid_data_o;
  logic              vid_valid_o;

  // host write port
  logic              host_wr_valid_i;
  logic              host_wr_ready_o;
  logic [FLAT_W-1:0] host_wr_addr_i;
  logic [DATA_W-1:0] host_wr_data_i;

  // host read-back port
  logic              host_rd_valid_i;
  logic              host_rd_ready_o;
  logic [FLAT_W-1:0] host_rd_addr_i;
  logic [DATA_W-1:0] host_rd_data_o;
  logic              host_rd_done_o;

  // range-fill engine
  logic              fill_start_i;
  logic [BANK_W-1:0] fill_bank_i;
  logic [ADDR_W-1:0] fill_first_i;
  logic [ADDR_W-1:0] fill_last_i;
  logic [DATA_W-1:0] fill_data_i;
  logic              busy_o;
  logic              fill_done_o;

  modport master (
    output vid_rd_en_i, vid_bank_i, vid_addr_i,
    input  vid_data_o, vid_valid_o,
    output host_wr_valid_i, host_wr_addr_i, host_wr_data_i,
    input  host_wr_ready_o,
    output host_rd_valid_i, host_rd_addr_i,
    input  host_rd_ready_o, host_rd_data_o, host_rd_done_o,
    output fill_start_i, fill_bank_i, fill_first_i, fill_last_i, fill_data_i,
    input  busy_o, fill_done_o
  );

  modport slave (
    input  vid_rd_en_i, vid_bank_i, vid_addr_i,
    output vid_data_o, vid_valid_o,
    input  host_wr_valid_i, host_wr_addr_i, host_wr_data_i,
    output host_wr_ready_o,
    input  host_rd_valid_i, host_rd_addr_i,
    output host_rd_ready_o, host_rd_data_o, host_rd_done_o,
    input  fill_start_i, fill_bank_i, fill_first_i, fill_last_i, fill_data_i,
    output busy_o, fill_done_o
  );
endinterface

// File: rtl/palette_bank_ram.sv
// Multi-bank palette RAM: 1-cycle video reads, host write/read-back ports,
// hardware init to DEFAULT_COLOR after reset and a wrapping range-fill engine.
module palette_bank_ram #(
  parameter int unsigned       DATA_W        = 16,
  parameter int unsigned       ADDR_W        = 8,
  parameter int unsigned       BANKS         = 2,
  parameter logic [DATA_W-1:0] DEFAULT_COLOR = DATA_W'(16'h0555)
) (
  input  logic                 clk,
  input  logic                 reset_n_i,
  palette_bank_ram_if.slave    bus
);

  localparam int unsigned BANK_W = $clog2(BANKS);
  localparam int unsigned FLAT_W = BANK_W + ADDR_W;
  localparam int unsigned DEPTH  = BANKS << ADDR_W;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_FILL = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [FLAT_W-1:0] r_init_cnt;
  logic [BANK_W-1:0] r_fill_bank;
  logic [ADDR_W-1:0] r_fill_ptr;
  logic [ADDR_W-1:0] r_fill_last;
  logic [DATA_W-1:0] r_fill_data;

  logic              w_init_end;
  logic              w_fill_end;
  logic              w_fill_go;
  logic              w_host_wr;
  logic              w_host_rd;
  logic              w_rd_allowed;

  logic              w_we;
  logic [FLAT_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [FLAT_W-1:0] w_raddr;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] r_vid_data;
  logic              r_vid_valid;
  logic [DATA_W-1:0] r_host_rd_data;
  logic              r_host_rd_done;
  logic              r_busy;
  logic              r_fill_done;

  // Handshake and arbitration terms; video always owns the read port when it asks.
  assign w_init_end   = (r_init_cnt == FLAT_W'(DEPTH - 1));
  assign w_fill_end   = (r_fill_ptr == r_fill_last);
  assign w_fill_go    = (r_state == ST_IDLE) && bus.fill_start_i;
  assign w_host_wr    = (r_state == ST_IDLE) && bus.host_wr_valid_i;
  assign w_rd_allowed = !bus.vid_rd_en_i && (r_state != ST_INIT);
  assign w_host_rd    = bus.host_rd_valid_i && w_rd_allowed;
  assign w_raddr      = bus.vid_rd_en_i ? {bus.vid_bank_i, bus.vid_addr_i}
                                        : bus.host_rd_addr_i;

  assign bus.host_wr_ready_o = (r_state == ST_IDLE);
  assign bus.host_rd_ready_o = w_rd_allowed;

  // State register
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (w_init_end)   w_state_nxt = ST_IDLE;
      ST_IDLE: if (w_fill_go)    w_state_nxt = ST_FILL;
      ST_FILL: if (w_fill_end)   w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_INIT;
    endcase
  end

  // Write-port selection: init sweep, host writes in IDLE, or fill sweep
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    case (r_state)
      ST_INIT: begin
        w_we    = 1'b1;
        w_waddr = r_init_cnt;
        w_wdata = DEFAULT_COLOR;
      end
      ST_IDLE: begin
        w_we    = w_host_wr;
        w_waddr = bus.host_wr_addr_i;
        w_wdata = bus.host_wr_data_i;
      end
      ST_FILL: begin
        w_we    = 1'b1;
        w_waddr = {r_fill_bank, r_fill_ptr};
        w_wdata = r_fill_data;
      end
      default: begin
        w_we    = 1'b0;
      end
    endcase
  end

  // Init counter and fill parameters; the fill pointer wraps mod 2**ADDR_W
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_init_cnt  <= '0;
      r_fill_bank <= '0;
      r_fill_ptr  <= '0;
      r_fill_last <= '0;
      r_fill_data <= '0;
    end else begin
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + FLAT_W'(1);
      end
      if (w_fill_go) begin
        r_fill_bank <= bus.fill_bank_i;
        r_fill_ptr  <= bus.fill_first_i;
        r_fill_last <= bus.fill_last_i;
        r_fill_data <= bus.fill_data_i;
      end else if (r_state == ST_FILL) begin
        r_fill_ptr  <= r_fill_ptr + ADDR_W'(1);
      end
    end
  end

  // Storage array, deliberately without reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Registered read outputs; a same-edge write is not visible (read-before-write)
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_vid_data     <= '0;
      r_vid_valid    <= 1'b0;
      r_host_rd_data <= '0;
      r_host_rd_done <= 1'b0;
      r_busy         <= 1'b1;
      r_fill_done    <= 1'b0;
    end else begin
      r_vid_valid    <= bus.vid_rd_en_i;
      if (r_state == ST_INIT) begin
        r_vid_data   <= '0;
      end else if (bus.vid_rd_en_i) begin
        r_vid_data   <= r_mem[w_raddr];
      end
      r_host_rd_done <= w_host_rd;
      if (w_host_rd) begin
        r_host_rd_data <= r_mem[w_raddr];
      end
      r_busy         <= (w_state_nxt != ST_IDLE);
      r_fill_done    <= (r_state == ST_FILL) && w_fill_end;
    end
  end

  assign bus.vid_data_o     = r_vid_data;
  assign bus.vid_valid_o    = r_vid_valid;
  assign bus.host_rd_data_o = r_host_rd_data;
  assign bus.host_rd_done_o = r_host_rd_done;
  assign bus.busy_o         = r_busy;
  assign bus.fill_done_o    = r_fill_done;

endmodule
